// File: rtl/sme_seq_pkg.sv
// Shared types and sizes for the string-match sequencer.
package sme_seq_pkg;

  localparam int unsigned STR_DEPTH = 32;
  localparam int unsigned PTN_DEPTH = 8;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [2:0] {
    StIdle,
    StSendStr,
    StSendPtn,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/sme_seq_if.sv
// Byte-serial link between the sequencer (master) and the matching engine (slave).
interface sme_seq_if;
  import sme_seq_pkg::*;

  logic [7:0]       eng_chardata;
  logic             eng_isstring;
  logic             eng_ispattern;
  logic             eng_valid;
  logic             eng_match;
  logic [IDX_W-1:0] eng_match_index;

  modport master (
    output eng_chardata, eng_isstring, eng_ispattern,
    input  eng_valid, eng_match, eng_match_index
  );

  modport slave (
    input  eng_chardata, eng_isstring, eng_ispattern,
    output eng_valid, eng_match, eng_match_index
  );

endinterface

// File: rtl/sme_seq_buf.sv
// String buffer and per-slot pattern buffers; synchronous write, asynchronous read.
module sme_seq_buf
  import sme_seq_pkg::*;
#(
  parameter int unsigned NPAT = 4
) (
  input  logic                         clk,
  input  logic                         str_we,
  input  logic [$clog2(STR_DEPTH)-1:0] str_waddr,
  input  logic [7:0]                   str_wdata,
  input  logic [$clog2(STR_DEPTH)-1:0] str_raddr,
  output logic [7:0]                   str_rdata,
  input  logic                         ptn_we,
  input  logic [((NPAT > 1) ? $clog2(NPAT) : 1)-1:0] ptn_wslot,
  input  logic [$clog2(PTN_DEPTH)-1:0] ptn_waddr,
  input  logic [7:0]                   ptn_wdata,
  input  logic [((NPAT > 1) ? $clog2(NPAT) : 1)-1:0] ptn_rslot,
  input  logic [$clog2(PTN_DEPTH)-1:0] ptn_raddr,
  output logic [7:0]                   ptn_rdata
);

  logic [7:0] str_mem [STR_DEPTH];
  logic [7:0] ptn_mem [NPAT][PTN_DEPTH];

  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_waddr] <= str_wdata;
    if (ptn_we) ptn_mem[ptn_wslot][ptn_waddr] <= ptn_wdata;
  end

  assign str_rdata = str_mem[str_raddr];
  assign ptn_rdata = ptn_mem[ptn_rslot][ptn_raddr];

endmodule

// File: rtl/sme_seq.sv
// Buffers a host string and up to NPAT patterns, then streams them to a matching engine
// one pattern at a time and collects per-pattern match results.
module sme_seq
  import sme_seq_pkg::*;
#(
  parameter int unsigned NPAT = 4,
  parameter int unsigned TMO  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_str,
  input  logic                  in_ptn,
  input  logic                  start,
  output logic                  busy,
  sme_seq_if.master             eng,
  output logic                  res_valid,
  output logic [NPAT-1:0]       res_match,
  output logic [IDX_W*NPAT-1:0] res_index,
  output logic                  err
);

  localparam int unsigned SlotW = (NPAT > 1) ? $clog2(NPAT) : 1;
  localparam int unsigned CntW  = $clog2(NPAT + 1);
  localparam int unsigned TmoW  = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int unsigned StrAw = $clog2(STR_DEPTH);
  localparam int unsigned PtnAw = $clog2(PTN_DEPTH);
  localparam int unsigned StrLw = StrAw + 1;
  localparam int unsigned PtnLw = PtnAw + 1;
  localparam logic [CntW-1:0]  NpatC   = CntW'(NPAT);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TMO - 1);
  localparam logic [StrLw-1:0] StrFull = StrLw'(STR_DEPTH);
  localparam logic [PtnLw-1:0] PtnFull = PtnLw'(PTN_DEPTH);

  state_e            state_q;
  logic [StrLw-1:0]  str_len_q;
  logic [CntW-1:0]   pat_cnt_q;
  logic [PtnLw-1:0]  ptn_len_q [NPAT];
  logic              prev_str_q, prev_ptn_q, burst_ok_q;
  logic [SlotW-1:0]  wr_slot_q;
  logic [StrAw-1:0]  str_idx_q;
  logic [PtnAw-1:0]  ptn_idx_q;
  logic [SlotW-1:0]  k_q;
  logic [TmoW-1:0]   tmo_q;

  logic                  busy_q, res_valid_q, err_q;
  logic [NPAT-1:0]       res_match_q;
  logic [IDX_W*NPAT-1:0] res_index_q;
  logic [7:0]            chardata_q;
  logic                  isstring_q, ispattern_q;

  logic              ptn_act, new_str, new_burst, str_we, ptn_we, last_pat;
  logic [StrAw-1:0]  str_waddr;
  logic [SlotW-1:0]  ptn_wslot;
  logic [PtnLw-1:0]  cur_len;
  logic [PtnAw-1:0]  ptn_waddr;
  logic [7:0]        str_rdata, ptn_rdata;

  // Load path: a string char always beats a simultaneous pattern char.
  always_comb begin
    ptn_act   = in_ptn & ~in_str;
    new_str   = in_str & ~prev_str_q;
    new_burst = ptn_act & ~prev_ptn_q;
    str_we    = ~busy_q & in_str & (new_str | (str_len_q != StrFull));
    str_waddr = new_str ? '0 : str_len_q[StrAw-1:0];
    ptn_wslot = new_burst ? pat_cnt_q[SlotW-1:0] : wr_slot_q;
    cur_len   = new_burst ? '0 : ptn_len_q[ptn_wslot];
    ptn_we    = ~busy_q & ptn_act &
                (new_burst ? (pat_cnt_q != NpatC) : (burst_ok_q & (cur_len != PtnFull)));
    ptn_waddr = cur_len[PtnAw-1:0];
    last_pat  = (k_q == SlotW'(pat_cnt_q - CntW'(1)));
  end

  sme_seq_buf #(
    .NPAT (NPAT)
  ) u_buf (
    .clk       (clk),
    .str_we    (str_we),
    .str_waddr (str_waddr),
    .str_wdata (in_data),
    .str_raddr (str_idx_q),
    .str_rdata (str_rdata),
    .ptn_we    (ptn_we),
    .ptn_wslot (ptn_wslot),
    .ptn_waddr (ptn_waddr),
    .ptn_wdata (in_data),
    .ptn_rslot (k_q),
    .ptn_raddr (ptn_idx_q),
    .ptn_rdata (ptn_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      str_len_q   <= '0;
      pat_cnt_q   <= '0;
      ptn_len_q   <= '{default: '0};
      prev_str_q  <= 1'b0;
      prev_ptn_q  <= 1'b0;
      burst_ok_q  <= 1'b0;
      wr_slot_q   <= '0;
      str_idx_q   <= '0;
      ptn_idx_q   <= '0;
      k_q         <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_match_q <= '0;
      res_index_q <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
    end else begin
      prev_str_q <= in_str;
      prev_ptn_q <= ptn_act;
      if (str_we) str_len_q <= {1'b0, str_waddr} + StrLw'(1);
      if (ptn_we) begin
        ptn_len_q[ptn_wslot] <= cur_len + PtnLw'(1);
        if (new_burst) begin
          pat_cnt_q <= pat_cnt_q + CntW'(1);
          wr_slot_q <= ptn_wslot;
        end
      end
      if (~busy_q & new_burst) burst_ok_q <= (pat_cnt_q != NpatC);

      // Engine strobes and res_valid are registered images of the current state.
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      if (res_valid_q) busy_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start && !busy_q) begin
            busy_q      <= 1'b1;
            res_match_q <= '0;
            res_index_q <= '0;
            err_q       <= 1'b0;
            str_idx_q   <= '0;
            ptn_idx_q   <= '0;
            k_q         <= '0;
            state_q     <= (str_len_q != '0 && pat_cnt_q != '0) ? StSendStr : StDone;
          end
        end
        StSendStr: begin
          chardata_q <= str_rdata;
          isstring_q <= 1'b1;
          if ({1'b0, str_idx_q} == str_len_q - StrLw'(1)) state_q <= StSendPtn;
          else str_idx_q <= str_idx_q + StrAw'(1);
        end
        StSendPtn: begin
          chardata_q  <= ptn_rdata;
          ispattern_q <= 1'b1;
          if ({1'b0, ptn_idx_q} == ptn_len_q[k_q] - PtnLw'(1)) begin
            state_q <= StWait;
            tmo_q   <= '0;
          end else begin
            ptn_idx_q <= ptn_idx_q + PtnAw'(1);
          end
        end
        StWait: begin
          if (eng.eng_valid || tmo_q == TmoLast) begin
            if (eng.eng_valid) begin
              res_match_q[k_q]                  <= eng.eng_match;
              res_index_q[IDX_W*k_q +: IDX_W]   <= eng.eng_match ? eng.eng_match_index : '0;
            end else begin
              res_match_q[k_q]                  <= 1'b0;
              res_index_q[IDX_W*k_q +: IDX_W]   <= '0;
              err_q                             <= 1'b1;
            end
            if (last_pat) begin
              state_q <= StDone;
            end else begin
              k_q       <= k_q + SlotW'(1);
              ptn_idx_q <= '0;
              state_q   <= StSendPtn;
            end
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDone: begin
          res_valid_q <= 1'b1;
          pat_cnt_q   <= '0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy              = busy_q;
  assign res_valid         = res_valid_q;
  assign res_match         = res_match_q;
  assign res_index         = res_index_q;
  assign err               = err_q;
  assign eng.eng_chardata  = chardata_q;
  assign eng.eng_isstring  = isstring_q;
  assign eng.eng_ispattern = ispattern_q;

endmodule

// File: tb/tb_sme_seq.sv
// Directed bench for sme_seq with a behavioural substring-search engine on the link.
module tb_sme_seq;
  import sme_seq_pkg::*;

  logic        clk, reset;
  logic [7:0]  in_data;
  logic        in_str, in_ptn, start;
  logic        busy, res_valid, err;
  logic [3:0]  res_match;
  logic [19:0] res_index;

  sme_seq_if ifc ();

  sme_seq #(
    .NPAT (4),
    .TMO  (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_str    (in_str),
    .in_ptn    (in_ptn),
    .start     (start),
    .busy      (busy),
    .eng       (ifc.master),
    .res_valid (res_valid),
    .res_match (res_match),
    .res_index (res_index),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: records what it is sent and answers after each pattern ends.
  byte         es[$];
  byte         ep[$];
  logic [63:0] str_all = '0;
  logic [63:0] ptn_all = '0;
  int          n_str = 0, n_ptn = 0, cyc = 0, p_num = 0, last_end = 0, gap = 0;
  bit          have_end = 0, prev_iss = 0, prev_isp = 0;
  logic [7:0]  silence = '0;

  function automatic int find_pat();
    for (int s = 0; s + ep.size() <= es.size(); s++) begin
      bit ok = 1;
      for (int j = 0; j < ep.size(); j++) if (es[s+j] != ep[j]) ok = 0;
      if (ok) return s;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int pos;
    cyc++;
    ifc.eng_valid       = 1'b0;
    ifc.eng_match       = 1'b0;
    ifc.eng_match_index = '0;
    if (ifc.eng_isstring) begin
      if (!prev_iss) begin es.delete(); p_num = 0; have_end = 0; end
      es.push_back(ifc.eng_chardata);
      str_all = {str_all[55:0], ifc.eng_chardata};
      n_str++;
    end
    if (ifc.eng_ispattern) begin
      if (!prev_isp) begin
        ep.delete();
        if (have_end) gap = cyc - last_end;
      end
      ep.push_back(ifc.eng_chardata);
      ptn_all = {ptn_all[55:0], ifc.eng_chardata};
      n_ptn++;
      last_end = cyc;
      have_end = 1;
    end else if (prev_isp) begin
      if (!silence[p_num[2:0]]) begin
        pos = find_pat();
        ifc.eng_valid       = 1'b1;
        ifc.eng_match       = (pos >= 0);
        ifc.eng_match_index = (pos >= 0) ? 5'(pos) : 5'd0;
      end
      p_num++;
    end
    prev_iss = ifc.eng_isstring;
    prev_isp = ifc.eng_ispattern;
  end

  task automatic load(input bit is_ptn, input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_data = s[i];
      if (is_ptn) in_ptn = 1'b1;
      else in_str = 1'b1;
    end
    @(negedge clk);
    in_str  = 1'b0;
    in_ptn  = 1'b0;
    in_data = 8'h00;
  endtask

  // Launch a job and wait for res_valid; lat counts negedges after the start edge.
  task automatic run_job(input bit poke, output int lat, output int ds, output int dp);
    int s0, p0;
    s0 = n_str;
    p0 = n_ptn;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    lat = 1;
    while (!res_valid && lat < 3000) begin
      if (poke) begin
        case (lat)
          3: begin in_str = 1'b1; in_data = "Z"; start = 1'b1; end
          4: begin in_str = 1'b0; start = 1'b0; in_ptn = 1'b1; in_data = "Q"; end
          6: begin in_ptn = 1'b0; in_data = 8'h00; end
          default: ;
        endcase
      end
      @(negedge clk);
      lat++;
    end
    check("job_done", res_valid, 1);
    check("busy_in_valid", busy, 1);
    ds = n_str - s0;
    dp = n_ptn - p0;
    @(negedge clk);
    check("valid_1cyc", res_valid, 0);
    check("busy_fall", busy, 0);
  endtask

  initial begin
    int lat, ds, dp, pulses;
    bit found;
    reset   = 1'b1;
    in_data = 8'h00;
    in_str  = 1'b0;
    in_ptn  = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_err", err, 0);
    check("rst_match", res_match, 0);
    check("rst_index", res_index, 0);
    check("rst_strobes", {ifc.eng_isstring, ifc.eng_ispattern, ifc.eng_chardata}, 0);
    reset = 1'b0;

    // Single pattern, single match
    load(0, "ABCD");
    load(1, "BC");
    run_job(0, lat, ds, dp);
    check("t1_nstr", ds, 4);
    check("t1_nptn", dp, 2);
    check("t1_str", str_all[31:0], 32'h41424344);
    check("t1_ptn", ptn_all[15:0], 16'h4243);
    check("t1_match", res_match, 4'b0001);
    check("t1_index", res_index, 20'd1);
    check("t1_err", err, 0);

    // Three patterns, string sent once
    load(0, "HELLO");
    load(1, "LL");
    load(1, "XY");
    load(1, "O");
    run_job(0, lat, ds, dp);
    check("t2_nstr", ds, 5);
    check("t2_nptn", dp, 5);
    check("t2_str", str_all[39:0], 40'h48454C4C4F);
    check("t2_ptn", ptn_all[39:0], 40'h4C4C58594F);
    check("t2_match", res_match, 4'b0101);
    check("t2_index", res_index, 20'd4098);
    check("t2_err", err, 0);

    // Engine silent on pattern 0: timeout then pattern 1
    load(0, "ABAB");
    load(1, "ZZ");
    load(1, "BA");
    silence = 8'h01;
    run_job(0, lat, ds, dp);
    silence = 8'h00;
    check("t3_gap", gap, 65);
    check("t3_nptn", dp, 4);
    check("t3_err", err, 1);
    check("t3_match", res_match, 4'b0010);
    check("t3_index", res_index, 20'd32);

    // No patterns buffered: straight to DONE
    run_job(0, lat, ds, dp);
    check("t4_lat", lat, 2);
    check("t4_strobes", ds + dp, 0);
    check("t4_match", res_match, 0);
    check("t4_err", err, 0);

    // Overlong string and pattern truncated; host pokes during the job are ignored
    load(0, "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn");
    load(1, "0123456789");
    run_job(1, lat, ds, dp);
    check("t5_nstr", ds, 32);
    check("t5_nptn", dp, 8);
    check("t5_slast", es[31], "f");
    check("t5_plast", ep[7], "7");
    check("t5_match", res_match, 0);

    load(1, "CDE");
    run_job(0, lat, ds, dp);
    check("t6_nstr", ds, 32);
    check("t6_sfirst", es[0], "A");
    check("t6_nptn", dp, 3);
    check("t6_match", res_match, 4'b0001);
    check("t6_index", res_index, 20'd2);

    // Reset during SEND_PTN aborts the job
    load(0, "ABCD");
    load(1, "BC");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (ifc.eng_ispattern) found = 1;
      else @(negedge clk);
    end
    check("t7_reach_ptn", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t7_isp", ifc.eng_ispattern, 0);
    check("t7_data", ifc.eng_chardata, 0);
    check("t7_busy", busy, 0);
    check("t7_match", res_match, 0);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    check("t7_no_valid", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sme_seq.md
SME_SEQ -- requirements
Module: sme_seq

Interface
REQ-001 Parameters: NPAT, default 4, number of buffered patterns per job; TMO, default 64, engine-response timeout in cycles.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_data  in  8  host character byte.
REQ-005 in_str  in  1  in_data is a string character.
REQ-006 in_ptn  in  1  in_data is a pattern character.
REQ-007 start  in  1  single-cycle pulse that launches a job on the buffered string and patterns.
REQ-008 busy  out  1  job in progress.
REQ-009 eng_chardata  out  8  byte driven to the matching engine.
REQ-010 eng_isstring / eng_ispattern  out  1 each  engine string and pattern strobes.
REQ-011 eng_valid, eng_match  in  1 each; eng_match_index  in  5  engine result.
REQ-012 res_valid  out  1  one-cycle job-complete pulse.
REQ-013 res_match  out  NPAT  bit k = pattern k matched.
REQ-014 res_index  out  5*NPAT  slice [5k+4:5k] = match index of pattern k, 0 if no match.
REQ-015 err  out  1  sticky timeout flag.

Function
REQ-016 Loading (only while busy=0): a string char is written to the 32x8 string buffer at str_len, then str_len increments; chars beyond 32 are dropped.
REQ-017 An in_str cycle that follows a cycle with in_str=0 starts a new string, resetting str_len to 0 before the write.
REQ-018 A pattern burst (in_ptn high after a low cycle) opens pattern slot pat_cnt; its chars fill the 8x8 slot; chars beyond 8 are dropped; bursts beyond NPAT are dropped.
REQ-019 If in_str and in_ptn are both high, in_str wins and the pattern char is ignored.
REQ-020 Load strobes and start are ignored while busy=1.
REQ-021 FSM states: IDLE, SEND_STR, SEND_PTN, WAIT, DONE.
REQ-022 IDLE->SEND_STR on start when str_len>0 and pat_cnt>0; otherwise IDLE->DONE.
REQ-023 busy rises the cycle after start and stays high through the res_valid cycle.
REQ-024 SEND_STR: for str_len consecutive cycles, eng_isstring=1 and eng_chardata=string[i], i=0..str_len-1; then go to SEND_PTN for pattern 0.
REQ-025 SEND_PTN: for the length of pattern k, eng_ispattern=1 with the pattern bytes in order; then go to WAIT.
REQ-026 WAIT: both strobes are 0 and the timeout counter increments.
REQ-027 On eng_valid in WAIT, store eng_match into res_match[k], and store eng_match_index into slice k if eng_match=1, else 0.
REQ-028 After storing a result, if k<pat_cnt-1 the FSM returns to SEND_PTN for k+1 without resending the string; otherwise it goes to DONE.
REQ-029 If the counter reaches TMO in WAIT without eng_valid, pattern k is recorded as no-match, err is set, and the FSM proceeds as in REQ-028.
REQ-030 eng_valid outside WAIT is ignored.
REQ-031 DONE lasts one cycle: res_valid=1, pat_cnt cleared, then IDLE; the string buffer is retained.
REQ-032 res_match and res_index hold their values until the next start, which clears them and err.
REQ-033 Outside SEND_STR and SEND_PTN, eng_chardata=0 and both strobes are 0.

Reset
REQ-034 Reset returns the FSM to IDLE and clears str_len, pat_cnt, all counters, busy, res_valid, res_match, res_index, err, eng_* outputs; buffer contents need not be cleared.
REQ-035 Reset asserted mid-job aborts the job with no res_valid pulse.

Structure
REQ-036 A shared package holds the state enum, the string depth (32), the pattern depth (8) and the index width (5).
REQ-037 One sub-module, sme_seq_buf, holds the string and pattern buffers with the write/read ports; the FSM stays in sme_seq.

Verification
REQ-038 Load "ABCD", pattern "BC", start with an engine model -> 4 isstring cycles, 2 ispattern cycles; engine returns match idx 1 -> res_match=0001, slice0=1, res_valid pulse, err=0.
REQ-039 Load string "HELLO", patterns "LL", "XY", "O", start -> string sent once, patterns sent sequentially; results res_match=0101, slice0=2, slice2=4.
REQ-040 Engine never asserts eng_valid for pattern 0 of 2 -> after 64 WAIT cycles pattern 1 is sent; err=1, res_match[0]=0.
REQ-041 start with pat_cnt=0 -> no eng strobes; res_valid the next-but-one cycle with res_match=0.
REQ-042 Load a 40-char string and a 10-char pattern -> only 32 and 8 chars are sent; in_str pulsed mid-job -> buffer unchanged.
REQ-043 Assert reset during SEND_PTN -> outputs cleared next cycle, no res_valid, busy=0.
